// File: rtl/modular_addsub_pipe.sv
// rtl/modular_addsub_pipe.sv - pipelined modular add/sub with valid/ready flow control
// Optional range-error output enabled by defining MODADDSUB_RANGE_CHECK_EN.
module modular_addsub_pipe #(
  parameter int              WIDTH   = 30,
  parameter longint unsigned MODULUS = 64'd1068564481,
  parameter int              STAGES  = 2,
  parameter int              TAG_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [TAG_W-1:0] tag_out
`ifdef MODADDSUB_RANGE_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [WIDTH:0] Q = (WIDTH+1)'(MODULUS);

  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("modular_addsub_pipe: STAGES must be 1 or 2");
  end

  // All stages move together; a held output freezes the whole pipe.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [WIDTH:0] sum, dif, raw_in;
  logic           fix_in;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    dif    = {1'b0, a} - {1'b0, b};
    raw_in = op ? dif : sum;
    fix_in = op ? (a < b) : (sum >= Q);
  end

`ifdef MODADDSUB_RANGE_CHECK_EN
  logic err_in;
  assign err_in = ({1'b0, a} >= Q) || ({1'b0, b} >= Q);
`endif

  // A borrowed difference wraps mod 2^(WIDTH+1); adding q lands it back in range.
  function automatic logic [WIDTH-1:0] reduce(input logic sub, input logic fix,
                                              input logic [WIDTH:0] raw);
    logic [WIDTH:0] t;
    t = !fix ? raw : (sub ? raw + Q : raw - Q);
    return WIDTH'(t);
  endfunction

  if (STAGES == 2) begin : g_two
    logic             s1_valid;
    logic             s1_op;
    logic             s1_fix;
    logic [WIDTH:0]   s1_raw;
    logic [TAG_W-1:0] s1_tag;
`ifdef MODADDSUB_RANGE_CHECK_EN
    logic             s1_err;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid  <= 1'b0;
        s1_op     <= 1'b0;
        s1_fix    <= 1'b0;
        s1_raw    <= '0;
        s1_tag    <= '0;
        out_valid <= 1'b0;
        c         <= '0;
        tag_out   <= '0;
`ifdef MODADDSUB_RANGE_CHECK_EN
        s1_err    <= 1'b0;
        err       <= 1'b0;
`endif
      end else if (adv) begin
        s1_valid  <= in_valid;
        s1_op     <= op;
        s1_fix    <= fix_in;
        s1_raw    <= raw_in;
        s1_tag    <= tag_in;
        out_valid <= s1_valid;
        c         <= reduce(s1_op, s1_fix, s1_raw);
        tag_out   <= s1_tag;
`ifdef MODADDSUB_RANGE_CHECK_EN
        s1_err    <= err_in;
        err       <= s1_err;
`endif
      end
    end
  end else begin : g_one
    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid <= 1'b0;
        c         <= '0;
        tag_out   <= '0;
`ifdef MODADDSUB_RANGE_CHECK_EN
        err       <= 1'b0;
`endif
      end else if (adv) begin
        out_valid <= in_valid;
        c         <= reduce(op, fix_in, raw_in);
        tag_out   <= tag_in;
`ifdef MODADDSUB_RANGE_CHECK_EN
        err       <= err_in;
`endif
      end
    end
  end

endmodule

// File: doc/modular_addsub_pipe.md
Name: modular_addsub_pipe

Overview:
- Parametrised, pipelined modular adder/subtractor with a per-item op select and valid/ready flow control on both sides.
- Generalises the single-cycle modular subtractor: width, modulus and pipeline depth are configurable, and add and subtract share one datapath.
- Used inside the NTT butterfly and pointwise datapaths between the coefficient memories and the multiplier, where downstream back-pressure must be honoured.

Parameters:
- WIDTH, 30, operand/result bit width; MODULUS must fit in WIDTH bits.
- MODULUS, 1068564481, prime modulus q; operands are required to be in [0, q-1].
- STAGES, 2, pipeline depth, 1 or 2; any other value is a static elaboration error.
- TAG_W, 8, width of the sideband tag carried alongside each item.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input item present.
- in_ready  out  1  block accepts the item this cycle.
- op  in  1  0 = (a+b) mod q, 1 = (a-b) mod q.
- a  in  WIDTH  operand a.
- b  in  WIDTH  operand b.
- tag_in  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- c  out  WIDTH  result in [0, q-1].
- tag_out  out  TAG_W  tag belonging to c.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge.
- Reset clears all stage valid bits: out_valid=0, c=0, tag_out=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight items; none are emitted afterwards.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv, combinational from out_ready and the output valid bit only, with no dependency on in_valid.
- When adv=0, every stage holds its data and valid bit. Held outputs (c, tag_out, out_valid) stay stable until accepted.
- Bubbles do not compress: stages move in lockstep on adv.
- Datapath (WIDTH+1-bit intermediates):
  - add: s = a+b; c = (s >= q) ? s-q : s.
  - sub: d = a-b; c = (a >= b) ? d : d+q.
- STAGES=2:
  - Stage 1 registers raw s/d, the compare flag, op and tag.
  - Stage 2 registers the corrected c.
  - Latency is 2 cycles from input transfer to out_valid with out_ready held high.
- STAGES=1: correction is done in the same cycle, latency 1. This matches the legacy subtractor timing.
- Throughput is 1 item/cycle while out_ready=1. Full pipeline with out_ready=0 accepts nothing.
- Simultaneous output accept and new input in the same cycle is legal and sustains full rate.
- Results for operands outside [0, q-1] are unspecified unless the optional feature is compiled in.
- Item order is strictly preserved; tag_out always equals the tag of the item on c.

Optional Feature:
- Macro MODADDSUB_RANGE_CHECK_EN.
- Defined:
  - Adds output port err (1 bit), aligned with c and valid only when out_valid=1.
  - err=1 iff the item's a >= q or b >= q. c is still computed by the formulas above.
  - err resets to 0.
- Undefined: no err port and no comparators; operands are trusted.

Test Plan:
- Sub, STAGES=1, out_ready=1, back-to-back items:
  - (10,0) -> 10
  - (10,8) -> 2
  - (10,11) -> 1068564480
  - (0,1068564480) -> 1
  - (1068564480,0) -> 1068564480
  - (1068564480,1068564480) -> 0
  - Each result appears 1 cycle after input.
- Add, STAGES=2:
  - (1068564480,1) -> 0
  - (1068564480,1068564480) -> 1068564479
  - (5,7) -> 12
  - out_valid asserts exactly 2 cycles after each transfer; tags 0x01,0x02,0x03 emerge in order.
- Back-pressure, STAGES=2: stream 6 items with tags 0..5, hold out_ready=0 for 4 cycles mid-stream.
  - in_ready drops once the pipe is full.
  - c/tag_out stay stable while stalled.
  - All 6 items are delivered in order with none lost or duplicated.
- Mixed op and full rate: alternate add/sub every cycle for 16 items with out_ready=1.
  - One result per cycle.
  - Matches a reference model for random operands in [0, q-1].
- Reset mid-stream: assert rst for 1 cycle with 2 items in flight.
  - Next cycle out_valid=0 and in_ready=1.
  - The in-flight items are never emitted.
  - A new item (3,4,add) -> 7 follows at normal latency.
- With MODADDSUB_RANGE_CHECK_EN defined:
  - (1068564481,0) -> err=1.
  - (1068564480,0) -> err=0.
  - err is only considered while out_valid=1.
